// File: rtl/led_matrix_driver_if.sv
// -----------------------------------------------------------------------------
// led_matrix_driver_if
// Frame-load handshake between a frame producer and led_matrix_driver.
//   frame_in    [63:0] LED pattern, bit index = row*8 + col, 1 = LED on
//   frame_valid        producer offers frame_in this cycle
//   frame_ready        driver's pending buffer is empty
// A frame transfers on any cycle where frame_valid and frame_ready are both 1.
// Modports: master = frame producer, slave = led_matrix_driver.
// -----------------------------------------------------------------------------
interface led_matrix_driver_if;
  logic [63:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;

  modport master (
    output frame_in,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_in,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/led_matrix_driver.sv
// -----------------------------------------------------------------------------
// led_matrix_driver
// Row-scanned 8x8 LED matrix driver with a double-buffered frame store.
// A new frame is written into a pending buffer and copied into the active
// (displayed) buffer only at a frame boundary, so a frame is never torn.
//
// Parameters:
//   ROW_DWELL     tick pulses each row is driven (0 behaves as 1)
// Build option:
//   LED_BLANK_EN  when defined, every row end passes through a one-tick BLANK
//                 state (all LEDs off) before the next row is driven
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_tick         one-cycle scan-rate enable
//   i_frm          frame-load handshake (slave side)
//   o_row   [7:0]  one-hot active-high row select (registered)
//   o_col_n [7:0]  active-low column drive for the selected row (registered)
//   o_row_idx[2:0] index of the row currently scanned (registered)
//   o_frame_done   one-cycle pulse when the row-7 dwell completes (registered)
// -----------------------------------------------------------------------------
module led_matrix_driver #(
  parameter int ROW_DWELL = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_tick,
  led_matrix_driver_if.slave        i_frm,
  output logic [7:0]                o_row,
  output logic [7:0]                o_col_n,
  output logic [2:0]                o_row_idx,
  output logic                      o_frame_done
);

  localparam int DWELL_EFF = (ROW_DWELL < 1) ? 1 : ROW_DWELL;
  // Wide enough to hold DWELL_EFF itself, since the incremented count is
  // compared against it.
  localparam int DW = $clog2(DWELL_EFF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_row_idx;
  logic [DW-1:0] r_dwell;
  logic [63:0]   r_active;
  logic [63:0]   r_pending;
  logic          r_pend_full;
  logic [7:0]    r_row;
  logic [7:0]    r_col_n;
  logic          r_frame_done;

  state_t        w_state_nxt;
  logic [2:0]    w_row_idx_nxt;
  logic [DW-1:0] w_dwell_nxt;
  logic [DW-1:0] w_dwell_inc;
  logic [63:0]   w_active_nxt;
  logic [63:0]   w_pending_nxt;
  logic          w_pend_full_nxt;
  logic          w_frame_done_nxt;
  logic          w_load;
  logic          w_accept;
  logic [7:0]    w_row_nxt;
  logic [7:0]    w_col_n_nxt;

  assign w_accept          = i_frm.frame_valid & ~r_pend_full;
  assign w_dwell_inc       = r_dwell + DW'(1);
  assign i_frm.frame_ready = ~r_pend_full;

  // Next-state logic: scan sequencing, dwell counting and frame-swap decision.
  always_comb begin
    w_state_nxt      = r_state;
    w_row_idx_nxt    = r_row_idx;
    w_dwell_nxt      = r_dwell;
    w_frame_done_nxt = 1'b0;
    w_load           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Ticks are ignored here; only a pending frame starts the scan.
        if (r_pend_full) begin
          w_load        = 1'b1;
          w_row_idx_nxt = 3'd0;
          w_dwell_nxt   = {DW{1'b0}};
          w_state_nxt   = ST_DRIVE;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (i_tick) begin
          if (w_dwell_inc >= DW'(DWELL_EFF)) begin
            w_dwell_nxt = {DW{1'b0}};
            if (r_row_idx == 3'd7) begin
              // Frame boundary: the only place the active buffer may change.
              w_row_idx_nxt    = 3'd0;
              w_frame_done_nxt = 1'b1;
              w_load           = r_pend_full;
            end else begin
              w_row_idx_nxt    = r_row_idx + 3'd1;
            end
`ifdef LED_BLANK_EN
            w_state_nxt = ST_BLANK;
`else
            w_state_nxt = ST_DRIVE;
`endif
          end else begin
            w_dwell_nxt = w_dwell_inc;
          end
        end else begin
          w_dwell_nxt = r_dwell;
        end
      end
      ST_BLANK: begin
`ifdef LED_BLANK_EN
        // row_idx already points at the next row; hold it for one tick.
        if (i_tick) begin
          w_state_nxt = ST_DRIVE;
        end else begin
          w_state_nxt = ST_BLANK;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Buffer update: accept into pending, promote pending to active on load.
  always_comb begin
    w_pending_nxt   = r_pending;
    w_pend_full_nxt = r_pend_full;
    if (w_accept) begin
      w_pending_nxt   = i_frm.frame_in;
      w_pend_full_nxt = 1'b1;
    end else if (w_load) begin
      w_pend_full_nxt = 1'b0;
    end else begin
      w_pend_full_nxt = r_pend_full;
    end
    if (w_load) begin
      w_active_nxt = r_pending;
    end else begin
      w_active_nxt = r_active;
    end
  end

  // Output decode from next-state values so the registered drive pattern
  // changes on the same edge that samples the terminating tick.
  always_comb begin
    w_row_nxt   = 8'h00;
    w_col_n_nxt = 8'hFF;
    if (w_state_nxt == ST_DRIVE) begin
      w_row_nxt   = 8'd1 << w_row_idx_nxt;
      w_col_n_nxt = ~w_active_nxt[{w_row_idx_nxt, 3'b000} +: 8];
    end else begin
      w_row_nxt   = 8'h00;
      w_col_n_nxt = 8'hFF;
    end
  end

  // State, buffer and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_row_idx    <= 3'd0;
      r_dwell      <= {DW{1'b0}};
      r_active     <= 64'd0;
      r_pending    <= 64'd0;
      r_pend_full  <= 1'b0;
      r_row        <= 8'h00;
      r_col_n      <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row_idx    <= w_row_idx_nxt;
      r_dwell      <= w_dwell_nxt;
      r_active     <= w_active_nxt;
      r_pending    <= w_pending_nxt;
      r_pend_full  <= w_pend_full_nxt;
      r_row        <= w_row_nxt;
      r_col_n      <= w_col_n_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign o_row        = r_row;
  assign o_col_n      = r_col_n;
  assign o_row_idx    = r_row_idx;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_led_matrix_driver.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_driver
// Directed-vector bench for led_matrix_driver. Two instances share clock and
// reset: u_dut1 with ROW_DWELL=4 and u_dut2 with ROW_DWELL=1.
// -----------------------------------------------------------------------------
module tb_led_matrix_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       tick2 = 1'b0;
  logic [7:0] row1, coln1, row2, coln2;
  logic [2:0] idx1, idx2;
  logic       fd1, fd2;

  int errors = 0;
  int checks = 0;

  led_matrix_driver_if if1 ();
  led_matrix_driver_if if2 ();

  led_matrix_driver #(.ROW_DWELL(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_frm(if1),
    .o_row(row1), .o_col_n(coln1), .o_row_idx(idx1), .o_frame_done(fd1)
  );

  led_matrix_driver #(.ROW_DWELL(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick2), .i_frm(if2),
    .o_row(row2), .o_col_n(coln2), .o_row_idx(idx2), .o_frame_done(fd2)
  );

  always #5 clk = ~clk;

`ifdef LED_BLANK_EN
  localparam int FRAME_TICKS = 40;
  localparam int IDX_SPACING = 6;
`else
  localparam int FRAME_TICKS = 32;
  localparam int IDX_SPACING = 3;
`endif

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick = 1'b0;
    tick2 = 1'b0;
    if1.frame_valid = 1'b0;
    if2.frame_valid = 1'b0;
    if1.frame_in = 64'd0;
    if2.frame_in = 64'd0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Offer one frame to dut1 for a single cycle (ready assumed high).
  task automatic load1(input logic [63:0] f);
    if1.frame_in = f;
    if1.frame_valid = 1'b1;
    step();
    if1.frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (row1 !== 8'h00) begin errors++; $display("FAIL reset_row: got %h expected %h", row1, 8'h00); end
    checks++; if (coln1 !== 8'hFF) begin errors++; $display("FAIL reset_col_n: got %h expected %h", coln1, 8'hFF); end
    checks++; if (idx1 !== 3'd0) begin errors++; $display("FAIL reset_row_idx: got %0d expected 0", idx1); end
    checks++; if (fd1 !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", fd1); end
    checks++; if (if1.frame_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", if1.frame_ready); end
    checks++; if (if2.frame_ready !== 1'b1 || row2 !== 8'h00) begin errors++; $display("FAIL reset_dut2: ready %b row %h expected 1 00", if2.frame_ready, row2); end
  endtask

  // Single LED at bit 0, tick every cycle.
  task automatic test_single_led();
    int bad;
    apply_reset();
    tick = 1'b1;
    load1(64'h1);
    checks++; if (if1.frame_ready !== 1'b0) begin errors++; $display("FAIL single_accept_ready: got %b expected 0", if1.frame_ready); end
    checks++; if (row1 !== 8'h00) begin errors++; $display("FAIL single_idle_row: got %h expected 00", row1); end
    step();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (row1 !== 8'h01 || coln1 !== 8'hFE) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_row0: %0d of 4 cycles wrong, expected row 01 col_n FE", bad); end
`ifdef LED_BLANK_EN
    checks++; if (row1 !== 8'h00 || coln1 !== 8'hFF) begin errors++; $display("FAIL single_blank: row %h col_n %h expected 00 FF", row1, coln1); end
    step();
`endif
    checks++; if (row1 !== 8'h02 || coln1 !== 8'hFF) begin errors++; $display("FAIL single_row1: row %h col_n %h expected 02 FF", row1, coln1); end
    checks++; if (idx1 !== 3'd1) begin errors++; $display("FAIL single_idx1: got %0d expected 1", idx1); end
    tick = 1'b0;
  endtask

  // Row 7 fully lit; frame_done cadence.
  task automatic test_row7_frame();
    int bad, on_cnt, n_pulse, first, second, dbl;
    logic prev_fd;
    apply_reset();
    tick = 1'b1;
    load1(64'hFF00_0000_0000_0000);
    bad = 0; on_cnt = 0; n_pulse = 0; first = 0; second = 0; dbl = 0; prev_fd = 1'b0;
    for (int k = 0; k < 110; k++) begin
      if (row1 == 8'h80) begin
        if (coln1 !== 8'h00) bad++;
        else on_cnt++;
      end else if (coln1 !== 8'hFF) begin
        bad++;
      end
      if (fd1 === 1'b1) begin
        if (prev_fd) dbl++;
        if (n_pulse == 0) first = k;
        if (n_pulse == 1) second = k;
        n_pulse++;
      end
      prev_fd = fd1;
      step();
    end
    tick = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL row7_pattern: %0d wrong cycles expected 0", bad); end
    checks++; if (on_cnt == 0) begin errors++; $display("FAIL row7_lit: saw %0d lit cycles expected >0", on_cnt); end
    checks++; if (n_pulse < 2) begin errors++; $display("FAIL row7_pulses: got %0d expected >=2", n_pulse); end
    checks++; if (n_pulse >= 2 && second - first != FRAME_TICKS) begin errors++; $display("FAIL row7_period: got %0d expected %0d", second - first, FRAME_TICKS); end
    checks++; if (dbl != 0) begin errors++; $display("FAIL row7_pulse_width: %0d wide pulses expected 0", dbl); end
  endtask

  // Accept B mid-frame, hold valid with C while not ready, swap at boundary.
  task automatic test_double_buffer();
    int bad_rdy, bad_col, got_fd;
    apply_reset();
    tick = 1'b1;
    load1({8{8'hA5}});
    for (int i = 0; i < 200 && idx1 != 3'd3; i++) step();
    checks++; if (idx1 !== 3'd3) begin errors++; $display("FAIL dbuf_wait_row3: got %0d expected 3", idx1); end
    if1.frame_in = 64'h0102_0408_1020_4080;
    if1.frame_valid = 1'b1;
    step();
    checks++; if (if1.frame_ready !== 1'b0) begin errors++; $display("FAIL dbuf_ready_low: got %b expected 0", if1.frame_ready); end
    // Keep offering a different frame that must never be taken.
    if1.frame_in = 64'hFFFF_FFFF_FFFF_FFFF;
    bad_rdy = 0; bad_col = 0; got_fd = 0;
    for (int i = 0; i < 100; i++) begin
      if (fd1 === 1'b1) begin got_fd = 1; break; end
      if (if1.frame_ready !== 1'b0) bad_rdy++;
      if (row1 != 8'h00) begin if (coln1 !== 8'h5A) bad_col++; end
      else if (coln1 !== 8'hFF) bad_col++;
      step();
    end
    if1.frame_valid = 1'b0;
    checks++; if (got_fd != 1) begin errors++; $display("FAIL dbuf_boundary: frame_done seen %0d expected 1", got_fd); end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL dbuf_ready_hold: %0d early-high cycles expected 0", bad_rdy); end
    checks++; if (bad_col != 0) begin errors++; $display("FAIL dbuf_midframe: %0d cycles not showing A expected 0", bad_col); end
    checks++; if (if1.frame_ready !== 1'b1) begin errors++; $display("FAIL dbuf_ready_back: got %b expected 1", if1.frame_ready); end
    for (int i = 0; i < 10 && row1 != 8'h01; i++) step();
    checks++; if (row1 !== 8'h01 || coln1 !== 8'h7F) begin errors++; $display("FAIL dbuf_row0_B: row %h col_n %h expected 01 7F", row1, coln1); end
    for (int i = 0; i < 20 && row1 != 8'h02; i++) step();
    checks++; if (row1 !== 8'h02 || coln1 !== 8'hBF) begin errors++; $display("FAIL dbuf_row1_B: row %h col_n %h expected 02 BF", row1, coln1); end
    // Next boundary: nothing pending, B is redisplayed and ready stays high.
    for (int i = 0; i < 60 && fd1 != 1'b1; i++) step();
    for (int i = 0; i < 10 && row1 != 8'h01; i++) step();
    checks++; if (row1 !== 8'h01 || coln1 !== 8'h7F || if1.frame_ready !== 1'b1) begin errors++; $display("FAIL dbuf_redisplay: row %h col_n %h ready %b expected 01 7F 1", row1, coln1, if1.frame_ready); end
    tick = 1'b0;
  endtask

  // Reset asserted mid row 5, then idle with ticks.
  task automatic test_reset_midframe();
    int bad;
    apply_reset();
    tick = 1'b1;
    load1({8{8'h3C}});
    for (int i = 0; i < 200 && idx1 != 3'd5; i++) step();
    checks++; if (idx1 !== 3'd5 || row1 !== 8'h20) begin errors++; $display("FAIL rstmid_wait_row5: idx %0d row %h expected 5 20", idx1, row1); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (row1 !== 8'h00 || coln1 !== 8'hFF) begin errors++; $display("FAIL rstmid_outputs: row %h col_n %h expected 00 FF", row1, coln1); end
    checks++; if (if1.frame_ready !== 1'b1 || idx1 !== 3'd0 || fd1 !== 1'b0) begin errors++; $display("FAIL rstmid_state: ready %b idx %0d fd %b expected 1 0 0", if1.frame_ready, idx1, fd1); end
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (row1 !== 8'h00 || coln1 !== 8'hFF || if1.frame_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_stay_idle: %0d lit cycles expected 0", bad); end
    tick = 1'b0;
  endtask

  // ROW_DWELL=1 with a tick every third cycle.
  task automatic test_dwell1();
    int last_chg, n_chg, bad_sp, n_wrap, bad_wrap;
    logic [2:0] prev_idx;
    apply_reset();
    if2.frame_in = {8{8'hFF}};
    if2.frame_valid = 1'b1;
    step();
    if2.frame_valid = 1'b0;
    step();
    checks++; if (row2 !== 8'h01 || coln2 !== 8'h00) begin errors++; $display("FAIL dw1_start: row %h col_n %h expected 01 00", row2, coln2); end
    prev_idx = idx2; last_chg = -1; n_chg = 0; bad_sp = 0; n_wrap = 0; bad_wrap = 0;
    for (int k = 0; k < 120; k++) begin
      tick2 = (k % 3 == 0);
      step();
      if (idx2 !== prev_idx) begin
        if (last_chg >= 0 && (k - last_chg) != IDX_SPACING) bad_sp++;
        if (idx2 == 3'd0) begin
          n_wrap++;
          if (prev_idx !== 3'd7 || fd2 !== 1'b1) bad_wrap++;
        end
        last_chg = k;
        n_chg++;
        prev_idx = idx2;
      end
    end
    tick2 = 1'b0;
    checks++; if (n_chg < 8) begin errors++; $display("FAIL dw1_changes: got %0d expected >=8", n_chg); end
    checks++; if (bad_sp != 0) begin errors++; $display("FAIL dw1_spacing: %0d bad gaps expected 0 (gap %0d)", bad_sp, IDX_SPACING); end
    checks++; if (n_wrap < 1) begin errors++; $display("FAIL dw1_wrap: got %0d wraps expected >=1", n_wrap); end
    checks++; if (bad_wrap != 0) begin errors++; $display("FAIL dw1_wrap_done: %0d wraps without 7->0 frame_done expected 0", bad_wrap); end
  endtask

  initial begin
    if1.frame_in = 64'd0;
    if1.frame_valid = 1'b0;
    if2.frame_in = 64'd0;
    if2.frame_valid = 1'b0;
    test_reset();
    test_single_led();
    test_row7_frame();
    test_double_buffer();
    test_reset_midframe();
    test_dwell1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_matrix_driver.md
LED_MATRIX_DRIVER -- requirements
Module: led_matrix_driver

Interface
REQ-001 The block SHALL have parameter ROW_DWELL, default 4, giving the number of tick pulses each row is driven; a value of 0 SHALL behave as 1.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous and active-high.
REQ-004 tick  input  1  scan-rate enable, one clk cycle wide; it SHALL be sampled only on clk edges.
REQ-005 frame_in  input  64  LED pattern; bit index = row*8 + col; 1 = LED on.
REQ-006 frame_valid  input  1  frame_in is valid this cycle.
REQ-007 frame_ready  output  1  the pending buffer is empty; a frame is accepted on any cycle where frame_valid and frame_ready are both 1.
REQ-008 row  output  8  one-hot, active-high row select.
REQ-009 col_n  output  8  active-low column drive for the selected row.
REQ-010 row_idx  output  3  index of the row currently driven.
REQ-011 frame_done  output  1  one-cycle pulse when the row-7 dwell completes.

Function
REQ-012 Buffering SHALL be double: a 64-bit pending buffer plus a pending-full flag, and a 64-bit active buffer.
- frame_ready SHALL equal the inverse of pending-full.
- An accept SHALL write frame_in into the pending buffer and set pending-full.
REQ-013 The FSM SHALL have three states:
- IDLE: row=0x00, col_n=0xFF.
- DRIVE: row one-hot of row_idx; col_n = ~active[row_idx*8 +: 8].
- BLANK: row=0x00, col_n=0xFF, row_idx held.
REQ-014 In IDLE, the cycle after pending-full is 1 the block SHALL copy pending to active, clear pending-full, set row_idx=0 and dwell=0, and enter DRIVE.
REQ-015 In IDLE, tick SHALL be ignored.
REQ-016 In DRIVE, each tick SHALL increment the dwell counter; the tick on which the count reaches ROW_DWELL SHALL end the row.
REQ-017 At a row end with row_idx<7, row_idx SHALL increment and dwell SHALL reset to 0.
REQ-018 At a row end with row_idx=7:
- frame_done SHALL pulse for exactly one cycle;
- row_idx SHALL wrap to 0;
- if pending-full is 1, pending SHALL copy to active and pending-full SHALL clear (frame swap); otherwise active is redisplayed unchanged.
REQ-019 Frame swaps SHALL occur only at frame boundaries; the active buffer SHALL never change mid-frame.
REQ-020 If an accept and a boundary with pending-full=0 occur in the same cycle, the new frame SHALL stay pending until the next boundary.
REQ-021 If pending-full=1 at a boundary, the swap and the clearing of pending-full SHALL occur together, and frame_ready SHALL go high on the following cycle.
REQ-022 row, col_n, row_idx and frame_done SHALL be registered outputs; the drive pattern SHALL change on the clk edge after the terminating tick.
REQ-023 The dwell counter SHALL be wide enough for ROW_DWELL with no overflow.

Reset
REQ-024 Asserting reset SHALL immediately force:
- state=IDLE, row=0x00, col_n=0xFF, row_idx=0;
- frame_done=0, dwell=0, pending-full=0, frame_ready=1;
- active and pending buffers = 0.
REQ-025 Reset asserted mid-frame SHALL discard both buffers; after release, no LED SHALL light until a new frame is accepted.

Configuration
REQ-026 Macro LED_BLANK_EN defined:
- every row end SHALL first enter BLANK for exactly one tick, then DRIVE the next row;
- this includes the row 7 to row 0 wrap; frame_done and the swap SHALL occur on entry to BLANK.
REQ-027 Macro LED_BLANK_EN undefined:
- BLANK SHALL be unreachable;
- row ends SHALL transition DRIVE to DRIVE directly.

Verification
REQ-028 Reset, then one frame with frame_in bit0=1 only, ROW_DWELL=4, tick every cycle:
- row=0x01, col_n=0xFE for 4 ticks;
- then row=0x02, col_n=0xFF.
REQ-029 Frame 0xFF00...00 (row 7 all on):
- col_n=0x00 only while row=0x80;
- frame_done pulses once per 32 ticks (LED_BLANK_EN undefined) or per 40 ticks (defined).
REQ-030 Accept frame B while frame A displays at row 3:
- frame_ready=0 until the row-7 boundary;
- the next row 0 shows B;
- frame_ready returns to 1.
REQ-031 Hold frame_valid=1 with frame_ready=0: no accept SHALL occur and the pending contents SHALL be unchanged.
REQ-032 Assert reset mid-row 5: outputs immediately row=0x00, col_n=0xFF, frame_ready=1; the block SHALL stay in IDLE with ticks until a new frame.
REQ-033 ROW_DWELL=1 with tick every 3 cycles: row_idx SHALL advance every 3 cycles and wrap 7 to 0 with a frame_done pulse.
